// File: rtl/pkg_system_mdr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkg_system_mdr : shared widths, types and loader states for the MDR system
// Rev 1.0
// ---------------------------------------------------------------------------
package pkg_system_mdr;

    localparam int DW  = 16;
    localparam int DW2 = 2 * DW;

    typedef logic [DW-1:0] operand_t;
    typedef logic [DW:0]   mcand_t;
    typedef logic [DW2:0]  data_mult_a_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        INIT   = 3'd3,
        RUN    = 3'd4,
        DONE   = 3'd5
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/mdr_iter_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdr_iter_counter : iteration counter with clear/enable, terminal count DW-1
// Rev 1.0
// ---------------------------------------------------------------------------
module mdr_iter_counter #(
    parameter int DW = 16,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(DW - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign o_tc = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mdr_operand_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdr_operand_loader : operand collection and iteration pacing for Booth mult
// Rev 1.0
// ---------------------------------------------------------------------------
module mdr_operand_loader
    import pkg_system_mdr::*;
#(
    parameter int DW = pkg_system_mdr::DW,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_load,
    input  logic [DW-1:0]   i_operand,
    output logic            o_load_ack,
    output logic            o_busy,
    output logic            o_init,
    output logic [2*DW:0]   o_acc_init,
    output logic [DW:0]     o_mcand,
    output logic [DW:0]     o_mcand_neg,
    output logic            o_shift_en,
    output logic            o_flag
);

    localparam logic [DW:0] C_ONE = (DW + 1)'(1);

    loader_state_e r_state;
    loader_state_e w_next;
    logic          w_cap_a;
    logic          w_cap_b;
    logic          w_tc;
    logic [DW:0]   w_mcand;

    logic [DW-1:0] r_a;
    logic          r_load_ack;
    logic          r_init;
    logic          r_shift_en;
    logic          r_flag;
    logic [2*DW:0] r_acc_init;
    logic [DW:0]   r_mcand;
    logic [DW:0]   r_mcand_neg;

    mdr_iter_counter #(
        .DW (DW),
        .CW (CW)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == INIT),
        .i_en  (r_state == RUN),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // i_load is only honoured in the two load states; i_start only in IDLE.
    always_comb begin
        w_next  = r_state;
        w_cap_a = 1'b0;
        w_cap_b = 1'b0;
        case (r_state)
            IDLE:    if (i_start) w_next = LOAD_A;
            LOAD_A:  if (i_load) begin
                         w_next  = LOAD_B;
                         w_cap_a = 1'b1;
                     end
            LOAD_B:  if (i_load) begin
                         w_next  = INIT;
                         w_cap_b = 1'b1;
                     end
            INIT:    w_next = RUN;
            RUN:     if (w_tc) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_mcand = {r_a[DW-1], r_a};

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a         <= '0;
            r_load_ack  <= 1'b0;
            r_init      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_flag      <= 1'b0;
            r_acc_init  <= '0;
            r_mcand     <= '0;
            r_mcand_neg <= '0;
        end else begin
            r_load_ack <= w_cap_a | w_cap_b;
            r_init     <= w_cap_b;
            r_shift_en <= (w_next == RUN);
            r_flag     <= (w_next == DONE);
            if (w_cap_a) begin
                r_a <= i_operand;
            end
            if (w_cap_b) begin
                r_acc_init  <= {{DW{1'b0}}, i_operand, 1'b0};
                r_mcand     <= w_mcand;
                r_mcand_neg <= ~w_mcand + C_ONE;
            end
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_load_ack  = r_load_ack;
    assign o_init      = r_init;
    assign o_shift_en  = r_shift_en;
    assign o_flag      = r_flag;
    assign o_acc_init  = r_acc_init;
    assign o_mcand     = r_mcand;
    assign o_mcand_neg = r_mcand_neg;

endmodule
`default_nettype wire

// File: tb/tb_mdr_operand_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mdr_operand_loader : randomized self-checking bench for the Booth loader
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mdr_operand_loader;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            i_start = 1'b0;
    logic            i_load = 1'b0;
    logic [DW-1:0]   i_operand = '0;
    logic            o_load_ack;
    logic            o_busy;
    logic            o_init;
    logic [2*DW:0]   o_acc_init;
    logic [DW:0]     o_mcand;
    logic [DW:0]     o_mcand_neg;
    logic            o_shift_en;
    logic            o_flag;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mdr_operand_loader #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_load      (i_load),
        .i_operand   (i_operand),
        .o_load_ack  (o_load_ack),
        .o_busy      (o_busy),
        .o_init      (o_init),
        .o_acc_init  (o_acc_init),
        .o_mcand     (o_mcand),
        .o_mcand_neg (o_mcand_neg),
        .o_shift_en  (o_shift_en),
        .o_flag      (o_flag)
    );

    typedef struct {
        int            n_ack;
        int            n_init;
        int            init_at;
        logic [2*DW:0] acc;
        logic [DW:0]   mc;
        logic [DW:0]   mn;
        int            n_shift;
        int            first_shift;
        int            n_flag;
        int            flag_at;
        int            n_busy;
        logic          busy_after;
        logic [2*DW:0] acc_hold;
    } obs_t;

    // Reference arithmetic: accumulator is 2*B, multiplicand is A as a signed
    // integer truncated to DW+1 bits, and its negation likewise.
    function automatic logic [2*DW:0] exp_acc(input logic [DW-1:0] b);
        longint v;
        v = longint'(b) * 2;
        return (2*DW+1)'(v);
    endfunction

    function automatic logic [DW:0] exp_mcand(input logic [DW-1:0] a);
        int sa;
        sa = int'($signed(a));
        return (DW+1)'(sa);
    endfunction

    function automatic logic [DW:0] exp_neg(input logic [DW-1:0] a);
        int sa;
        sa = int'($signed(a));
        return (DW+1)'(0 - sa);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation and records what the DUT did. Sample k=1 is the
    // cycle right after the edge that captured B.
    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int gap_a, input int gap_b, input bit skip_start,
                         input bit hold, input int start_pulse_at, output obs_t o);
        o.n_ack = 0; o.n_init = 0; o.init_at = -1; o.acc = '0; o.mc = '0; o.mn = '0;
        o.n_shift = 0; o.first_shift = -1; o.n_flag = 0; o.flag_at = -1;
        o.n_busy = 0; o.busy_after = 1'b1; o.acc_hold = '0;
        if (!skip_start) begin
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
        end
        i_load = 1'b0;
        repeat (gap_a) begin
            tick();
            if (o_load_ack) o.n_ack++;
        end
        i_operand = a;
        i_load    = 1'b1;
        tick();
        if (o_load_ack) o.n_ack++;
        if (!hold) begin
            i_load = 1'b0;
            repeat (gap_b) begin
                i_operand = DW'($urandom);
                tick();
                if (o_load_ack) o.n_ack++;
            end
        end
        i_operand = b;
        i_load    = 1'b1;
        tick();
        for (int k = 1; k <= DW + 6; k++) begin
            if (k > 1) tick();
            if (!(hold && k < 3)) i_load = 1'b0;
            i_start = (k == start_pulse_at);
            if (o_load_ack) o.n_ack++;
            if (o_init) begin
                o.n_init++;
                o.init_at = k;
                o.acc = o_acc_init;
                o.mc  = o_mcand;
                o.mn  = o_mcand_neg;
            end
            if (o_shift_en) begin
                o.n_shift++;
                if (o.first_shift < 0) o.first_shift = k;
            end
            if (o_flag) begin
                o.n_flag++;
                o.flag_at = k;
            end
            if (k <= DW + 2 && o_busy) o.n_busy++;
            if (k == DW + 3) o.busy_after = o_busy;
        end
        i_start = 1'b0;
        i_load  = 1'b0;
        o.acc_hold = o_acc_init;
    endtask

    task automatic load_one(input logic [DW-1:0] v);
        i_operand = v;
        i_load    = 1'b1;
        tick();
        i_load    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
        n_checks++;
        if ({o_load_ack, o_init, o_shift_en, o_flag} !== 4'b0000)
            $display("FAIL reset_strobes: got %b want 0000", {o_load_ack, o_init, o_shift_en, o_flag});
        else n_pass++;
        n_checks++;
        if ({o_acc_init, o_mcand, o_mcand_neg} !== '0)
            $display("FAIL reset_data: got %h %h %h want 0", o_acc_init, o_mcand, o_mcand_neg);
        else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        obs_t o;
        do_op(16'd3, 16'hFFFB, 0, 0, 1'b0, 1'b0, 0, o);
        n_checks++;
        if (o.n_ack !== 2) $display("FAIL dir_acks: got %0d want 2", o.n_ack); else n_pass++;
        n_checks++;
        if (o.init_at !== 1 || o.n_init !== 1)
            $display("FAIL dir_init: at %0d count %0d want at 1 count 1", o.init_at, o.n_init);
        else n_pass++;
        n_checks++;
        if (o.acc !== 33'h0_0001_FFF6) $display("FAIL dir_acc: got %h want 0_0001_fff6", o.acc); else n_pass++;
        n_checks++;
        if (o.mc !== 17'h00003) $display("FAIL dir_mcand: got %h want 00003", o.mc); else n_pass++;
        n_checks++;
        if (o.mn !== 17'h1FFFD) $display("FAIL dir_mcand_neg: got %h want 1fffd", o.mn); else n_pass++;
        n_checks++;
        if (o.n_shift !== DW || o.first_shift !== 2)
            $display("FAIL dir_shift: count %0d first %0d want %0d first 2", o.n_shift, o.first_shift, DW);
        else n_pass++;
        n_checks++;
        if (o.flag_at !== DW + 2 || o.n_flag !== 1)
            $display("FAIL dir_flag: at %0d count %0d want at %0d count 1", o.flag_at, o.n_flag, DW + 2);
        else n_pass++;
        n_checks++;
        if (o.n_busy !== DW + 2 || o.busy_after !== 1'b0)
            $display("FAIL dir_busy: cycles %0d after %b want %0d after 0", o.n_busy, o.busy_after, DW + 2);
        else n_pass++;

        do_op(16'h8000, 16'h0001, 1, 2, 1'b0, 1'b0, 0, o);
        n_checks++;
        if (o.mc !== 17'h18000) $display("FAIL min_mcand: got %h want 18000", o.mc); else n_pass++;
        n_checks++;
        if (o.mn !== 17'h08000) $display("FAIL min_mcand_neg: got %h want 08000", o.mn); else n_pass++;
    endtask

    task automatic test_random();
        obs_t o;
        logic [DW-1:0] a, b;
        for (int i = 0; i < 10; i++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            do_op(a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0, 0, o);
            n_checks++;
            if (o.acc !== exp_acc(b) || o.mc !== exp_mcand(a) || o.mn !== exp_neg(a))
                $display("FAIL rnd_data[%0d]: got %h %h %h want %h %h %h", i,
                         o.acc, o.mc, o.mn, exp_acc(b), exp_mcand(a), exp_neg(a));
            else n_pass++;
            n_checks++;
            if (o.n_ack !== 2 || o.n_shift !== DW || o.flag_at !== DW + 2 || o.n_flag !== 1)
                $display("FAIL rnd_timing[%0d]: acks %0d shifts %0d flag_at %0d flags %0d want 2 %0d %0d 1",
                         i, o.n_ack, o.n_shift, o.flag_at, o.n_flag, DW, DW + 2);
            else n_pass++;
            n_checks++;
            if (o.acc_hold !== exp_acc(b))
                $display("FAIL rnd_hold[%0d]: got %h want %h", i, o.acc_hold, exp_acc(b));
            else n_pass++;
        end
    endtask

    task automatic test_ignore();
        obs_t o;
        logic [DW-1:0] a, b;
        a = DW'($urandom);
        b = DW'($urandom);
        i_operand = DW'($urandom);
        i_load = 1'b1;
        tick();
        tick();
        i_load = 1'b0;
        n_checks++;
        if (o_load_ack !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL idle_load: ack %b busy %b want 0 0", o_load_ack, o_busy);
        else n_pass++;
        i_start = 1'b1;
        i_load  = 1'b1;
        tick();
        i_start = 1'b0;
        i_load  = 1'b0;
        n_checks++;
        if (o_load_ack !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL start_and_load: ack %b busy %b want 0 1", o_load_ack, o_busy);
        else n_pass++;
        do_op(a, b, 1, 1, 1'b1, 1'b0, 6, o);
        n_checks++;
        if (o.n_ack !== 2 || o.flag_at !== DW + 2 || o.n_flag !== 1 || o.busy_after !== 1'b0)
            $display("FAIL run_start: acks %0d flag_at %0d flags %0d after %b want 2 %0d 1 0",
                     o.n_ack, o.flag_at, o.n_flag, o.busy_after, DW + 2);
        else n_pass++;
        n_checks++;
        if (o.mc !== exp_mcand(a) || o.acc !== exp_acc(b))
            $display("FAIL run_start_data: got %h %h want %h %h", o.mc, o.acc, exp_mcand(a), exp_acc(b));
        else n_pass++;
    endtask

    task automatic test_hold_load();
        obs_t o;
        logic [DW-1:0] a, b;
        a = DW'($urandom);
        b = DW'($urandom);
        do_op(a, b, 0, 0, 1'b0, 1'b1, 0, o);
        n_checks++;
        if (o.n_ack !== 2 || o.init_at !== 1)
            $display("FAIL hold_acks: acks %0d init_at %0d want 2 1", o.n_ack, o.init_at);
        else n_pass++;
        n_checks++;
        if (o.mc !== exp_mcand(a) || o.acc !== exp_acc(b))
            $display("FAIL hold_data: got %h %h want %h %h", o.mc, o.acc, exp_mcand(a), exp_acc(b));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int cnt;
        cnt = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        load_one(DW'($urandom));
        load_one(DW'($urandom));
        for (int k = 0; k < 40 && cnt < 7; k++) begin
            tick();
            if (o_shift_en) cnt++;
        end
        n_checks++;
        if (cnt !== 7) $display("FAIL mid_reach: shifts %0d want 7", cnt); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({o_busy, o_load_ack, o_init, o_shift_en, o_flag} !== 5'b00000 ||
            {o_acc_init, o_mcand, o_mcand_neg} !== '0)
            $display("FAIL mid_reset: strobes %b data %h %h %h want 0",
                     {o_busy, o_load_ack, o_init, o_shift_en, o_flag}, o_acc_init, o_mcand, o_mcand_neg);
        else n_pass++;
        tick();
        rst = 1'b1;
        tick();
        do_op(16'd1, 16'd1, 0, 0, 1'b0, 1'b0, 0, o);
        n_checks++;
        if (o.acc !== 33'h0_0000_0002 || o.mc !== 17'h00001 || o.mn !== 17'h1FFFF)
            $display("FAIL post_reset_data: got %h %h %h want 000000002 00001 1ffff", o.acc, o.mc, o.mn);
        else n_pass++;
        n_checks++;
        if (o.flag_at !== DW + 2 || o.n_ack !== 2)
            $display("FAIL post_reset_timing: flag_at %0d acks %0d want %0d 2", o.flag_at, o.n_ack, DW + 2);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a1, b1, a2, b2;
        int  n_flag;
        bit  seen;
        a1 = DW'($urandom); b1 = DW'($urandom);
        a2 = DW'($urandom); b2 = DW'($urandom);
        seen = 1'b0;
        n_flag = 0;
        i_start = 1'b1;
        tick();
        load_one(a1);
        load_one(b1);
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (o_flag) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL b2b_first_flag: got none want 1"); else n_pass++;
        tick();
        n_checks++;
        if (o_busy !== 1'b0 || o_flag !== 1'b0)
            $display("FAIL b2b_idle: busy %b flag %b want 0 0", o_busy, o_flag);
        else n_pass++;
        tick();
        n_checks++;
        if (o_busy !== 1'b1 || o_load_ack !== 1'b0)
            $display("FAIL b2b_restart: busy %b ack %b want 1 0", o_busy, o_load_ack);
        else n_pass++;
        i_start = 1'b0;
        load_one(a2);
        load_one(b2);
        n_checks++;
        if (o_init !== 1'b1 || o_acc_init !== exp_acc(b2) || o_mcand !== exp_mcand(a2))
            $display("FAIL b2b_second_init: init %b acc %h mc %h want 1 %h %h",
                     o_init, o_acc_init, o_mcand, exp_acc(b2), exp_mcand(a2));
        else n_pass++;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (o_flag) n_flag++;
        end
        n_checks++;
        if (n_flag !== 1 || o_busy !== 1'b0)
            $display("FAIL b2b_second_flag: flags %0d busy %b want 1 0", n_flag, o_busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore();
        test_hold_load();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
